// File: rtl/rvc_fetch_aligner.sv
// RVC fetch aligner: buffers up to two naturally aligned fetch words and
// hands one 16-bit or 32-bit instruction per cycle to decode. It also walks
// the fetch address, including redirects that land on the upper halfword.
module rvc_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] fetch_addr,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [15:0] inst16,
  output logic [31:0] inst32,
  output logic        inst_compressed
);

  typedef enum logic {STREAM, SKIP_HALF} state_t;

  state_t      state_q, state_d;
  logic [63:0] sbuf_q, sbuf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] faddr_q, faddr_d;

  logic [2:0]  need;
  logic        consume;
  logic        accept;
  logic [63:0] shifted;
  logic [2:0]  cnt_c;
  logic        flush_pc_unused;

  // Keep only the lowest n valid halfwords of the buffer.
  function automatic logic [63:0] keep_low(input logic [63:0] b, input logic [2:0] n);
    logic [63:0] m;
    case (n)
      3'd0:    m = 64'h0000_0000_0000_0000;
      3'd1:    m = 64'h0000_0000_0000_FFFF;
      3'd2:    m = 64'h0000_0000_FFFF_FFFF;
      3'd3:    m = 64'h0000_FFFF_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return b & m;
  endfunction

  // Place a word (or a halfword in w[15:0]) starting at halfword slot pos.
  function automatic logic [63:0] place(input logic [31:0] w, input logic [2:0] pos);
    logic [63:0] r;
    case (pos)
      3'd0:    r = {32'h0, w};
      3'd1:    r = {16'h0, w, 16'h0};
      3'd2:    r = {w, 32'h0};
      3'd3:    r = {w[15:0], 48'h0};
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  // bit0 of a redirect target has no meaning for halfword-aligned code.
  assign flush_pc_unused = flush_pc[0];

  // An empty buffer reports a non-compressed head so the cleared state reads all zero.
  assign inst_compressed = (cnt_q != 3'd0) && (sbuf_q[1:0] != 2'b11);
  assign need            = inst_compressed ? 3'd1 : 3'd2;
  assign inst_valid      = (cnt_q >= need) && !flush;
  assign fetch_ready     = (cnt_q <= 3'd2) && !flush;
  assign consume         = inst_valid && inst_ready;
  assign accept          = fetch_valid && fetch_ready;
  assign inst16          = sbuf_q[15:0];
  assign inst32          = sbuf_q[31:0];
  assign inst_pc         = pc_q;
  assign fetch_addr      = faddr_q;

  // Next-state: flush redirect, else consume the head then append the accepted word.
  always_comb begin
    state_d = state_q;
    sbuf_d  = sbuf_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    faddr_d = faddr_q;
    shifted = sbuf_q;
    cnt_c   = cnt_q;
    if (flush) begin
      sbuf_d  = 64'h0;
      cnt_d   = 3'd0;
      pc_d    = {flush_pc[31:1], 1'b0};
      faddr_d = {flush_pc[31:2], 2'b00};
      state_d = flush_pc[1] ? SKIP_HALF : STREAM;
    end else begin
      if (consume) begin
        shifted = inst_compressed ? {16'h0, sbuf_q[63:16]} : {32'h0, sbuf_q[63:32]};
        cnt_c   = cnt_q - need;
        pc_d    = pc_q + {28'h0, need, 1'b0};
      end
      sbuf_d = shifted;
      cnt_d  = cnt_c;
      if (accept) begin
        if (state_q == SKIP_HALF) begin
          sbuf_d  = keep_low(shifted, cnt_c) | place({16'h0, fetch_data[31:16]}, cnt_c);
          cnt_d   = cnt_c + 3'd1;
          state_d = STREAM;
        end else begin
          sbuf_d  = keep_low(shifted, cnt_c) | place(fetch_data, cnt_c);
          cnt_d   = cnt_c + 3'd2;
        end
        faddr_d = faddr_q + 32'd4;
      end
    end
  end

  // State registers with synchronous reset that also clears the buffer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= STREAM;
      sbuf_q  <= 64'h0;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_PC;
      faddr_q <= {RESET_PC[31:2], 2'b00};
    end else begin
      state_q <= state_d;
      sbuf_q  <= sbuf_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      faddr_q <= faddr_d;
    end
  end

endmodule

// File: doc/rvc_fetch_aligner.md
Name: rvc_fetch_aligner

Overview:
- Sits between the instruction fetch port and the decompressor/decode stage.
- Accepts naturally aligned 32-bit fetch words and buffers up to two words (four halfwords).
- Extracts one instruction per cycle, either 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary.
- Presents the low halfword to the decompressor and the full 32-bit candidate to decode, and sequences fetch addresses, including halfword-aligned redirects.

Parameters:
- RESET_PC, 32'h0000_0200, PC of the first instruction after reset.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous active-high reset.
- fetch_addr  output  32  word-aligned address of the next fetch word.
- fetch_valid  input  1  fetch_data holds the word at fetch_addr.
- fetch_ready  output  1  aligner accepts fetch_data this cycle.
- fetch_data  input  32  fetched word.
- flush  input  1  redirect request.
- flush_pc  input  32  redirect target, halfword aligned; bit0 is ignored.
- inst_valid  output  1  head instruction is complete.
- inst_ready  input  1  downstream consumes the head instruction.
- inst_pc  output  32  PC of the head instruction.
- inst16  output  16  head halfword, driven to the decompressor.
- inst32  output  32  head two halfwords, raw.
- inst_compressed  output  1  head instruction is 16-bit.

Behaviour:
- State
  - buf: 64-bit shift buffer; head halfword at [15:0].
  - cnt: 0..4 valid halfwords.
  - pc: PC of the head instruction.
  - faddr: next fetch address.
  - FSM states: STREAM and SKIP_HALF.
- Reset: synchronous, on RST high at a CLK edge; overrides everything, including a mid-transfer fetch.
  - cnt=0, pc=RESET_PC, faddr={RESET_PC[31:2],2'b00}, FSM=STREAM.
  - Outputs after reset: inst_valid=0, fetch_ready=1, inst16/inst32/inst_compressed=0 (buffer cleared).
- Combinational outputs
  - inst16=buf[15:0]; inst32=buf[31:0]; inst_compressed=(buf[1:0]!=2'b11).
  - need = 1 when compressed, else 2.
  - inst_valid = (cnt>=need) and not flush.
  - inst_pc=pc; fetch_addr=faddr.
  - fetch_ready = (cnt<=2) and not flush. Computed from registered cnt only; consumption in the same cycle does not raise it.
- Consume (inst_valid & inst_ready): shift buf right by 16*need, cnt-=need, pc+=2*need (32-bit wrap).
- Accept (fetch_valid & fetch_ready)
  - STREAM: append all 32 bits at halfword position cnt' (cnt after any same-cycle consume); cnt'+=2.
  - SKIP_HALF: append fetch_data[31:16] only; cnt'+=1; FSM->STREAM.
  - Either state: faddr+=4.
- Simultaneous consume and accept in one cycle is legal: consume first, then append. cnt never exceeds 4.
- Latency: fetch word accepted at edge N gives inst_valid at cycle N+1 if enough halfwords are present.
  - Straddling 32-bit instruction (cnt=1, head halfword [1:0]=11): inst_valid=0 until the next word is accepted.
- Flush (highest priority after RST)
  - cnt=0, pc={flush_pc[31:1],1'b0}, faddr={flush_pc[31:2],2'b00}.
  - FSM=SKIP_HALF if flush_pc[1] else STREAM.
  - Any fetch word presented in the flush cycle is dropped; no consume happens in that cycle.
- Decompressor control (c_ena) is driven by decode from inst_compressed; this block does not gate it.
- inst16/inst32 contents are don't-care when inst_valid=0, but must be stable while inst_valid=1 and inst_ready=0.

Test Plan:
1. Reset, fetch 32'h0000_0513, inst_ready=1 -> next cycle inst_valid=1, inst_pc=0x200, inst_compressed=0, inst32=0x00000513; then cnt=0, inst_valid=0, fetch_addr=0x204.
2. Fetch 32'h4505_4501 -> two consecutive instructions: inst16=0x4501 at pc 0x200, then inst16=0x4505 at pc 0x202, inst_compressed=1 both.
3. Straddle: word0=32'h0513_4501, word1=32'h4505_0000 delayed 3 cycles.
   - c.li at 0x200.
   - inst_valid low until word1 arrives, then inst32=0x00000513 at 0x202.
   - Then inst16=0x4505 at 0x206.
4. Backpressure: inst_ready=0, two words accepted (cnt=4) -> fetch_ready=0, fetch_addr holds, inst_pc and inst16 stable; raising inst_ready drains in order.
5. flush with flush_pc=0x302 while cnt=3 -> inst_valid=0 that cycle; fetch_addr=0x300; word 32'h4505_1234 yields inst16=0x4505, inst_pc=0x302; lower halfword discarded.
6. RST asserted mid-stream (cnt=3, fetch_valid=1) -> next cycle inst_valid=0, fetch_ready=1, fetch_addr=0x200, inst_pc=0x200, and the concurrent fetch word is dropped.
